// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA sequencer owning FF46; takes the memory bus from the CPU
// during a 160-byte copy and lets high-RAM accesses through in one-cycle slots.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DST_BASE     = 16'hFE00,
  parameter int          NUM_BYTES    = 160,
  parameter logic [15:0] HRAM_LO      = 16'hFF80,
  parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_wait_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_rd_n,
  output logic        mem_wr_n,
  input  logic [7:0]  mem_data_in,
  output logic        dma_active
);
  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);
  typedef enum logic [2:0] {IDLE, START, READ, WRITE, CPU_SLOT} state_t;
  state_t state_q, state_d;
  logic [7:0] dma_src_q, dma_src_d, idx_q, idx_d, data_latch_q, data_latch_d;
  logic wr_q, is_reg, hram_req, trig, last;
  assign is_reg     = cpu_addr == DMA_REG_ADDR;
  assign hram_req   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI) && (!cpu_rd_n || !cpu_wr_n);
  assign trig       = is_reg && !cpu_wr_n && wr_q;
  assign last       = idx_q == LAST_IDX;
  assign dma_active = state_q != IDLE;
  always_comb begin
    state_d      = state_q;
    dma_src_d    = dma_src_q;
    idx_d        = idx_q;
    data_latch_d = data_latch_q;
    mem_addr     = cpu_addr;
    mem_data_out = cpu_data_out;
    mem_rd_n     = cpu_rd_n;
    mem_wr_n     = cpu_wr_n | is_reg;
    cpu_data_in  = is_reg ? dma_src_q : mem_data_in;
    cpu_wait_n   = 1'b1;
    case (state_q)
      IDLE, CPU_SLOT: state_d = (state_q == CPU_SLOT) ? READ : IDLE;
      START: begin
        mem_rd_n = 1'b1;
        mem_wr_n = 1'b1;
        state_d  = hram_req ? CPU_SLOT : READ;
      end
      READ: begin
        mem_addr     = {dma_src_q, idx_q};
        mem_rd_n     = 1'b0;
        mem_wr_n     = 1'b1;
        data_latch_d = mem_data_in;
        state_d      = WRITE;
      end
      WRITE: begin
        mem_addr     = DST_BASE + {8'h00, idx_q};
        mem_data_out = data_latch_q;
        mem_rd_n     = 1'b1;
        mem_wr_n     = 1'b0;
        idx_d        = last ? idx_q : idx_q + 8'd1;
        state_d      = last ? IDLE : (hram_req ? CPU_SLOT : READ);
      end
      default: state_d = IDLE;
    endcase
    // Outside the slot the CPU never sees the bus: HRAM stalls, everything else is absorbed.
    if (state_q != IDLE && state_q != CPU_SLOT) begin
      cpu_wait_n  = !hram_req;
      cpu_data_in = is_reg ? dma_src_q : 8'hFF;
    end
    if (trig) begin
      dma_src_d = cpu_data_out;
      idx_d     = 8'h00;
      state_d   = START;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dma_src_q    <= 8'h00;
      idx_q        <= 8'h00;
      data_latch_q <= 8'h00;
      wr_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      dma_src_q    <= dma_src_d;
      idx_q        <= idx_d;
      data_latch_q <= data_latch_d;
      wr_q         <= cpu_wr_n;
    end
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: bench for oam_dma_ctrl with a flat 64K memory behind the bus
// and a copy-level reference of the expected bus trace and OAM contents.
module tb_oam_dma_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic [7:0]  cpu_data_in, mem_data_out, mem_data_in;
  logic        cpu_wait_n, mem_rd_n, mem_wr_n, dma_active;
  logic [15:0] mem_addr;

  oam_dma_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n), .cpu_data_in(cpu_data_in),
    .cpu_wait_n(cpu_wait_n), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n), .mem_data_in(mem_data_in),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign mem_data_in = mem[mem_addr];
  always @(posedge clk) if (!mem_wr_n) mem[mem_addr] <= mem_data_out;

  typedef struct packed { logic wr; logic [15:0] addr; logic [7:0] data; } op_t;
  typedef struct {
    logic [15:0] addr; logic rd_n, wr_n; logic [7:0] wdata;
    logic [7:0] exp_din; logic exp_wait, exp_mrd, exp_mwr, chk_din;
  } vec_t;

  op_t  trace[$], exp_q[$];
  int   trace_cyc[$];
  int   cyc = 0, act_cnt = 0, tcyc = 0, checks = 0, errors = 0;
  logic [7:0] snap_a [0:255], snap_b [0:255], hram_m [0:127];
  vec_t idle_v [4], dma_v [5];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (dma_active) act_cnt++;
  always @(negedge clk)
    if (rst_n && (!mem_rd_n || !mem_wr_n)) begin
      trace.push_back({!mem_wr_n, mem_addr, mem_wr_n ? mem_data_in : mem_data_out});
      trace_cyc.push_back(cyc);
    end

  function automatic bit is_hram(logic [15:0] a);
    return a >= 16'hFF80 && a <= 16'hFFFE;
  endfunction

  function automatic logic [15:0] rand_other();
    logic [15:0] a;
    do a = 16'($urandom); while (a == 16'hFF46 || is_hram(a));
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    cpu_addr = 16'h0000; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  task automatic prep(input logic [7:0] src, input bit b);
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'($urandom);
    for (int i = 0; i < 256; i++)
      if (b) snap_b[i] = mem[{src, 8'(i)}]; else snap_a[i] = mem[{src, 8'(i)}];
    for (int i = 0; i < 127; i++) hram_m[i] = mem[16'hFF80 + 16'(i)];
  endtask

  task automatic push_copy(input logic [7:0] src, input int n, input bit b);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, src, 8'(i), b ? snap_b[i] : snap_a[i]});
      exp_q.push_back({1'b1, 16'hFE00 + 16'(i), b ? snap_b[i] : snap_a[i]});
    end
  endtask

  task automatic trigger(input logic [7:0] s, input int hold);
    trace.delete(); trace_cyc.delete(); exp_q.delete(); act_cnt = 0;
    cpu_addr = 16'hFF46; cpu_data_out = s; cpu_rd_n = 1'b1; cpu_wr_n = 1'b0; tcyc = cyc;
    repeat (hold) tick();
    idle_bus();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!dma_active) break;
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL %s: dma_active still high after %0d cycles, required low", nm, n);
    end
    tick();
  endtask

  task automatic cmp_trace(input string nm);
    op_t f[$];
    int ok = 0;
    foreach (trace[i]) if (!is_hram(trace[i].addr)) f.push_back(trace[i]);
    chk({nm, " bus ops"}, f.size(), exp_q.size());
    for (int i = 0; i < f.size() && i < exp_q.size(); i++) if (f[i] === exp_q[i]) ok++;
    chk({nm, " ops matching"}, ok, exp_q.size());
  endtask

  task automatic cmp_oam(input string nm, input bit b);
    int ok = 0;
    for (int i = 0; i < 160; i++)
      if (mem[16'hFE00 + 16'(i)] === (b ? snap_b[i] : snap_a[i])) ok++;
    chk({nm, " oam bytes"}, ok, 160);
  endtask

  function automatic int hram_ops();
    int n = 0;
    foreach (trace[i]) if (is_hram(trace[i].addr)) n++;
    return n;
  endfunction

  task automatic cmp_hram(input string nm);
    int ok = 0;
    for (int i = 0; i < 127; i++) if (mem[16'hFF80 + 16'(i)] === hram_m[i]) ok++;
    chk({nm, " hram bytes"}, ok, 127);
  endtask

  task automatic hram_op(input logic [15:0] a, input bit wr, input logic [7:0] d, output int stall);
    cpu_addr = a; cpu_data_out = d; cpu_rd_n = wr; cpu_wr_n = !wr; stall = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cpu_wait_n) break;
      stall++;
      tick();
    end
    if (!wr) chk("hram read data", cpu_data_in, hram_m[a[6:0]]);
    else hram_m[a[6:0]] = d;
    chk("hram stall 1..2", 32'(stall >= 1 && stall <= 2), 1);
    tick();
    idle_bus();
  endtask

  task automatic apply(input vec_t v, input string nm, input bit dma);
    cpu_addr = v.addr; cpu_rd_n = v.rd_n; cpu_wr_n = v.wr_n; cpu_data_out = v.wdata;
    @(negedge clk);
    chk({nm, " wait_n"}, cpu_wait_n, v.exp_wait);
    if (v.chk_din) chk({nm, " data_in"}, cpu_data_in, v.exp_din);
    if (!dma) begin
      chk({nm, " mem_addr"}, mem_addr, v.addr);
      chk({nm, " mem_rd_n"}, mem_rd_n, v.exp_mrd);
      chk({nm, " mem_wr_n"}, mem_wr_n, v.exp_mwr);
      if (!v.wr_n) chk({nm, " mem_data_out"}, mem_data_out, v.wdata);
    end
    tick();
    idle_bus();
  endtask

  initial begin
    int st, nh, r;
    logic [7:0] src, oam_pre;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    idle_v[0] = '{16'h8000, 1'b0, 1'b1, 8'h00, mem[16'h8000], 1'b1, 1'b0, 1'b1, 1'b1};
    idle_v[1] = '{16'hC000, 1'b1, 1'b0, 8'h5A, 8'h00,         1'b1, 1'b1, 1'b0, 1'b0};
    idle_v[2] = '{16'hFF46, 1'b0, 1'b1, 8'h00, 8'h00,         1'b1, 1'b0, 1'b1, 1'b1};
    idle_v[3] = '{16'hFF90, 1'b0, 1'b1, 8'h00, mem[16'hFF90], 1'b1, 1'b0, 1'b1, 1'b1};
    dma_v[0]  = '{16'h8000, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    dma_v[1]  = '{16'hC000, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    dma_v[2]  = '{16'hFF46, 1'b0, 1'b1, 8'h00, 8'hC1, 1'b1, 1'b1, 1'b1, 1'b1};
    dma_v[3]  = '{16'hFFFF, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    dma_v[4]  = '{16'hFF7F, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (2) tick();
    cpu_addr = 16'hFF46; cpu_rd_n = 1'b0;
    #2;
    chk("reset dma_active", dma_active, 0);
    chk("reset wait_n", cpu_wait_n, 1);
    chk("reset ff46 read", cpu_data_in, 8'h00);
    idle_bus();
    tick();
    rst_n = 1'b1;
    tick();

    foreach (idle_v[i]) apply(idle_v[i], $sformatf("idle vec %0d", i), 1'b0);
    chk("idle write reached mem", mem[16'hC000], 8'h5A);

    prep(8'hC1, 1'b0);
    trigger(8'hC1, 1);
    foreach (dma_v[i]) apply(dma_v[i], $sformatf("dma vec %0d", i), 1'b1);
    wait_idle("c1 copy");
    push_copy(8'hC1, 160, 1'b0);
    cmp_trace("c1 copy");
    cmp_oam("c1 copy", 1'b0);
    chk("c1 active cycles", act_cnt, 321);
    chk("c1 first read cycle", trace_cyc.size() > 0 ? trace_cyc[0] - tcyc : -1, 2);
    chk("c1 last write cycle", trace_cyc.size() > 0 ? trace_cyc[trace_cyc.size() - 1] - tcyc : -1, 321);
    chk("dropped write c000", mem[16'hC000], 8'h5A);

    prep(8'hC1, 1'b0);
    trigger(8'hC1, 1);
    repeat (20) tick();
    hram_op(16'hFF90, 1'b0, 8'h00, st);
    wait_idle("hram slot");
    push_copy(8'hC1, 160, 1'b0);
    cmp_trace("hram slot");
    cmp_oam("hram slot", 1'b0);
    chk("hram slot active cycles", act_cnt, 322);
    chk("hram slot bus ops", hram_ops(), 1);

    prep(8'hC1, 1'b0);
    prep(8'hD0, 1'b1);
    trigger(8'hC1, 1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!mem_wr_n && mem_addr == 16'hFE31) break;
    end
    tick();
    cpu_addr = 16'hFF46; cpu_data_out = 8'hD0; cpu_wr_n = 1'b0;
    tick();
    idle_bus();
    wait_idle("retrigger");
    push_copy(8'hC1, 50, 1'b0);
    exp_q.push_back({1'b0, 16'hC132, snap_a[50]});
    push_copy(8'hD0, 160, 1'b1);
    cmp_trace("retrigger");
    cmp_oam("retrigger", 1'b1);
    chk("retrigger active cycles", act_cnt, 423);

    prep(8'h77, 1'b0);
    trigger(8'h77, 3);
    wait_idle("held write");
    push_copy(8'h77, 160, 1'b0);
    cmp_trace("held write");
    cmp_oam("held write", 1'b0);
    chk("held write active cycles", act_cnt, 321);

    for (int it = 0; it < 4; it++) begin
      src = 8'($urandom_range(0, 253));
      prep(src, 1'b0);
      trigger(src, 1);
      nh = 0;
      while (cyc - tcyc < 250) begin
        r = $urandom_range(0, 9);
        if (r < 4) tick();
        else if (r == 4 || r == 6) begin
          cpu_addr = rand_other(); cpu_rd_n = (r == 6); cpu_wr_n = (r != 6); cpu_data_out = 8'($urandom);
          @(negedge clk);
          chk("rnd other wait_n", cpu_wait_n, 1);
          if (r == 4) chk("rnd other read", cpu_data_in, 8'hFF);
          tick();
          idle_bus();
        end else if (r == 5) begin
          cpu_addr = 16'hFF46; cpu_rd_n = 1'b0;
          @(negedge clk);
          chk("rnd ff46 read", cpu_data_in, src);
          chk("rnd ff46 wait_n", cpu_wait_n, 1);
          tick();
          idle_bus();
        end else begin
          a = 16'hFF80 + 16'($urandom_range(0, 126));
          hram_op(a, r == 9, 8'($urandom), st);
          nh++;
        end
      end
      wait_idle("rnd copy");
      push_copy(src, 160, 1'b0);
      cmp_trace($sformatf("rnd %0d", it));
      cmp_oam($sformatf("rnd %0d", it), 1'b0);
      cmp_hram($sformatf("rnd %0d", it));
      chk("rnd active cycles", act_cnt, 321 + nh);
      chk("rnd hram slots", hram_ops(), nh);
    end

    prep(8'h42, 1'b0);
    oam_pre = mem[16'hFE64];
    trigger(8'h42, 1);
    repeat (30) tick();
    rst_n = 1'b0;
    cpu_addr = 16'h8000; cpu_rd_n = 1'b0;
    #2;
    chk("midreset dma_active", dma_active, 0);
    chk("midreset wait_n", cpu_wait_n, 1);
    chk("midreset mem_addr", mem_addr, 16'h8000);
    chk("midreset mem_rd_n", mem_rd_n, 0);
    chk("midreset data_in", cpu_data_in, mem[16'h8000]);
    cpu_addr = 16'hFF46;
    #1;
    chk("midreset ff46 read", cpu_data_in, 8'h00);
    idle_bus();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("post reset idle", dma_active, 0);
    chk("uncopied byte 100", mem[16'hFE64], oam_pre);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
